// File: rtl/branch_pkg.sv
// Shared branch-predictor types: BHT counter encodings, queued update payload
// and the BHT index-port grant.
package branch_pkg;

   localparam int unsigned BHT_TABLE_WIDTH = 3;

   localparam logic [1:0] BHT_STRONG_NOT_TAKEN = 2'b00;
   localparam logic [1:0] BHT_WEAK_NOT_TAKEN   = 2'b01;
   localparam logic [1:0] BHT_WEAK_TAKEN       = 2'b10;
   localparam logic [1:0] BHT_STRONG_TAKEN     = 2'b11;

   typedef struct packed {
      logic [BHT_TABLE_WIDTH-1:0] slice;
      logic                       taken;
   } bht_update_t;

   typedef enum logic {
      GRANT_LOOKUP = 1'b0,
      GRANT_DRAIN  = 1'b1
   } grant_e;

endpackage

// File: rtl/bht_update_fifo.sv
// Queue of resolved branch outcomes awaiting a BHT write slot.
// A push into a full queue is only legal when it coincides with a pop.
module bht_update_fifo
   import branch_pkg::*;
#(
   parameter int unsigned depth = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  bht_update_t              push_data_i,
   input  logic                     pop_i,
   output bht_update_t              head_o,
   output logic [$clog2(depth):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned PW = $clog2(depth);
   localparam int unsigned CW = PW + 1;

   bht_update_t     mem_q [depth];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push, do_pop;

   assign full_o  = (count_q == CW'(depth));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Storage needs no reset: an empty count hides any stale contents.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   no_overflow_a: assert property (@(posedge clk) disable iff (rst)
      !(push_i && full_o && !pop_i))
      else $error("bht_update_fifo: push into full queue without pop");

endmodule

// File: rtl/bht_update_arbiter.sv
// Arbitrates the BHT index port between ID lookups and queued EX updates,
// flags mispredictions and keeps saturating resolve/mispredict counts.
module bht_update_arbiter
   import branch_pkg::*;
#(
   parameter int unsigned table_width = BHT_TABLE_WIDTH,
   parameter int unsigned queue_depth = 4,
   parameter int unsigned max_wait    = 4,
   parameter int unsigned ctr_width   = 16
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [table_width-1:0]           id_pc_slice,
   input  logic                             id_is_branch,
   input  logic                             ex_resolve_valid,
   input  logic [table_width-1:0]           ex_pc_slice,
   input  logic                             ex_taken,
   input  logic                             ex_predicted_taken,
   input  logic                             bht_predict_taken,
   output logic [table_width-1:0]           bht_pc_slice,
   output logic                             bht_attempt_branch,
   output logic                             bht_branch_taken,
   output logic                             id_predict_taken,
   output logic                             id_predict_valid,
   output logic                             id_stall,
   output logic                             ex_mispredict,
   output logic [$clog2(queue_depth):0]     q_count,
   output logic [ctr_width-1:0]             resolve_count,
   output logic [ctr_width-1:0]             mispredict_count
);

   localparam int unsigned CW = $clog2(queue_depth) + 1;
   localparam int unsigned WW = $clog2(max_wait + 1);

   bht_update_t       push_entry, head;
   logic [CW-1:0]     count;
   logic              full, empty;
   grant_e            grant_c;
   logic              stall_c;
   logic [WW-1:0]     head_wait_q, head_wait_d;
   logic [ctr_width-1:0] resolve_q, resolve_d, mispredict_q, mispredict_d;

   assign push_entry.slice = BHT_TABLE_WIDTH'(ex_pc_slice);
   assign push_entry.taken = ex_taken;

   bht_update_fifo #(
      .depth (queue_depth)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (ex_resolve_valid),
      .push_data_i (push_entry),
      .pop_i       (grant_c == GRANT_DRAIN),
      .head_o      (head),
      .count_o     (count),
      .full_o      (full),
      .empty_o     (empty)
   );

   // Lookups win unless ID is idle or the head can no longer be deferred.
   always_comb begin
      grant_c = GRANT_LOOKUP;
      stall_c = 1'b0;
      if (!empty) begin
         if (!id_is_branch) begin
            grant_c = GRANT_DRAIN;
         end else if (full || (head_wait_q == WW'(max_wait))) begin
            grant_c = GRANT_DRAIN;
            stall_c = 1'b1;
         end
      end
   end

   always_comb begin
      bht_pc_slice       = id_pc_slice;
      bht_attempt_branch = 1'b0;
      bht_branch_taken   = 1'b0;
      id_predict_valid   = id_is_branch;
      id_predict_taken   = bht_predict_taken & id_is_branch;
      if (grant_c == GRANT_DRAIN) begin
         bht_pc_slice       = table_width'(head.slice);
         bht_attempt_branch = 1'b1;
         bht_branch_taken   = head.taken;
         id_predict_valid   = 1'b0;
         id_predict_taken   = 1'b0;
      end
   end

   assign id_stall      = stall_c;
   assign ex_mispredict = ex_resolve_valid && (ex_taken != ex_predicted_taken);
   assign q_count       = count;

   always_comb begin
      head_wait_d = head_wait_q;
      if (grant_c == GRANT_DRAIN) begin
         head_wait_d = '0;
      end else if (!empty && (head_wait_q != WW'(max_wait))) begin
         head_wait_d = head_wait_q + WW'(1);
      end
   end

   always_comb begin
      resolve_d    = resolve_q;
      mispredict_d = mispredict_q;
      if (ex_resolve_valid && (resolve_q != '1)) resolve_d = resolve_q + ctr_width'(1);
      if (ex_mispredict && (mispredict_q != '1)) mispredict_d = mispredict_q + ctr_width'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_wait_q  <= '0;
         resolve_q    <= '0;
         mispredict_q <= '0;
      end else begin
         head_wait_q  <= head_wait_d;
         resolve_q    <= resolve_d;
         mispredict_q <= mispredict_d;
      end
   end

   assign resolve_count    = resolve_q;
   assign mispredict_count = mispredict_q;

endmodule

// File: tb/tb_bht_update_arbiter.sv
// Directed bench for bht_update_arbiter (queue_depth=4, max_wait=4, ctr_width=2).
module tb_bht_update_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] id_pc_slice;
   logic       id_is_branch;
   logic       ex_resolve_valid;
   logic [2:0] ex_pc_slice;
   logic       ex_taken;
   logic       ex_predicted_taken;
   logic       bht_predict_taken;
   logic [2:0] bht_pc_slice;
   logic       bht_attempt_branch;
   logic       bht_branch_taken;
   logic       id_predict_taken;
   logic       id_predict_valid;
   logic       id_stall;
   logic       ex_mispredict;
   logic [2:0] q_count;
   logic [1:0] resolve_count;
   logic [1:0] mispredict_count;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   bht_update_arbiter #(
      .table_width (3),
      .queue_depth (4),
      .max_wait    (4),
      .ctr_width   (2)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .id_pc_slice        (id_pc_slice),
      .id_is_branch       (id_is_branch),
      .ex_resolve_valid   (ex_resolve_valid),
      .ex_pc_slice        (ex_pc_slice),
      .ex_taken           (ex_taken),
      .ex_predicted_taken (ex_predicted_taken),
      .bht_predict_taken  (bht_predict_taken),
      .bht_pc_slice       (bht_pc_slice),
      .bht_attempt_branch (bht_attempt_branch),
      .bht_branch_taken   (bht_branch_taken),
      .id_predict_taken   (id_predict_taken),
      .id_predict_valid   (id_predict_valid),
      .id_stall           (id_stall),
      .ex_mispredict      (ex_mispredict),
      .q_count            (q_count),
      .resolve_count      (resolve_count),
      .mispredict_count   (mispredict_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex(input logic v, input logic [2:0] s, input logic t, input logic p);
      ex_resolve_valid   = v;
      ex_pc_slice        = s;
      ex_taken           = t;
      ex_predicted_taken = p;
   endtask

   initial begin
      rst = 1'b1;
      id_pc_slice = '0;
      id_is_branch = 1'b0;
      bht_predict_taken = 1'b0;
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      #12;
      check("rst_q_count", 32'(q_count), 32'd0);
      check("rst_attempt", 32'(bht_attempt_branch), 32'd0);
      check("rst_stall", 32'(id_stall), 32'd0);
      check("rst_resolve", 32'(resolve_count), 32'd0);
      check("rst_mispred", 32'(mispredict_count), 32'd0);
      rst = 1'b0;
      tick();

      // Plain lookup on an empty queue
      id_is_branch = 1'b1; id_pc_slice = 3'd5; bht_predict_taken = 1'b0;
      #1;
      check("lk_valid", 32'(id_predict_valid), 32'd1);
      check("lk_taken", 32'(id_predict_taken), 32'd0);
      check("lk_slice", 32'(bht_pc_slice), 32'd5);
      check("lk_attempt", 32'(bht_attempt_branch), 32'd0);
      check("lk_q", 32'(q_count), 32'd0);
      bht_predict_taken = 1'b1;
      #1;
      check("lk_taken1", 32'(id_predict_taken), 32'd1);
      bht_predict_taken = 1'b0;

      // Resolve then drain on the next idle ID cycle
      id_is_branch = 1'b0;
      ex(1'b1, 3'd2, 1'b1, 1'b1);
      #1;
      check("d_mispred0", 32'(ex_mispredict), 32'd0);
      check("d_attempt_n", 32'(bht_attempt_branch), 32'd0);
      tick();
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      check("d_q1", 32'(q_count), 32'd1);
      check("d_slice", 32'(bht_pc_slice), 32'd2);
      check("d_attempt", 32'(bht_attempt_branch), 32'd1);
      check("d_taken", 32'(bht_branch_taken), 32'd1);
      check("d_pvalid", 32'(id_predict_valid), 32'd0);
      check("d_stall", 32'(id_stall), 32'd0);
      tick();
      check("d_q0", 32'(q_count), 32'd0);
      check("d_resolve", 32'(resolve_count), 32'd1);

      // Head deferred max_wait cycles, then forced drain with stall
      id_is_branch = 1'b1; id_pc_slice = 3'd3;
      ex(1'b1, 3'd6, 1'b0, 1'b0);
      tick();
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("w_pvalid%0d", i), 32'(id_predict_valid), 32'd1);
         check($sformatf("w_stall%0d", i), 32'(id_stall), 32'd0);
         check($sformatf("w_attempt%0d", i), 32'(bht_attempt_branch), 32'd0);
         tick();
      end
      #1;
      check("w_force_stall", 32'(id_stall), 32'd1);
      check("w_force_pvalid", 32'(id_predict_valid), 32'd0);
      check("w_force_attempt", 32'(bht_attempt_branch), 32'd1);
      check("w_force_slice", 32'(bht_pc_slice), 32'd6);
      check("w_force_taken", 32'(bht_branch_taken), 32'd0);
      tick();
      check("w_q0", 32'(q_count), 32'd0);
      check("w_resolve", 32'(resolve_count), 32'd2);

      // Mispredict flag and saturating statistics
      id_is_branch = 1'b0;
      ex(1'b1, 3'd1, 1'b1, 1'b0);
      #1;
      check("m_flag", 32'(ex_mispredict), 32'd1);
      tick();
      ex(1'b1, 3'd2, 1'b0, 1'b1);
      #1;
      check("m_flag2", 32'(ex_mispredict), 32'd1);
      check("m_cnt1", 32'(mispredict_count), 32'd1);
      check("m_res3", 32'(resolve_count), 32'd3);
      tick();
      ex(1'b1, 3'd3, 1'b1, 1'b0);
      #1;
      check("m_cnt2", 32'(mispredict_count), 32'd2);
      check("m_res_sat", 32'(resolve_count), 32'd3);
      tick();
      ex(1'b1, 3'd4, 1'b0, 1'b1);
      #1;
      check("m_cnt3", 32'(mispredict_count), 32'd3);
      tick();
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      check("m_cnt_sat", 32'(mispredict_count), 32'd3);
      check("m_res_sat2", 32'(resolve_count), 32'd3);
      check("m_q1", 32'(q_count), 32'd1);
      check("m_slice4", 32'(bht_pc_slice), 32'd4);
      tick();
      check("m_q0", 32'(q_count), 32'd0);

      // Back-to-back resolves fill the queue; full forces drain with push
      id_is_branch = 1'b1; id_pc_slice = 3'd7;
      for (int i = 0; i < 6; i++) begin
         ex(1'b1, 3'(i + 1), 1'((i + 1) % 2), 1'((i + 1) % 2));
         #1;
         if (i < 4) begin
            check($sformatf("f_q%0d", i), 32'(q_count), 32'(i));
            check($sformatf("f_pvalid%0d", i), 32'(id_predict_valid), 32'd1);
            check($sformatf("f_stall%0d", i), 32'(id_stall), 32'd0);
         end else begin
            check($sformatf("f_qfull%0d", i), 32'(q_count), 32'd4);
            check($sformatf("f_stall%0d", i), 32'(id_stall), 32'd1);
            check($sformatf("f_slice%0d", i), 32'(bht_pc_slice), 32'(i - 3));
            check($sformatf("f_taken%0d", i), 32'(bht_branch_taken), 32'((i - 3) % 2));
         end
         tick();
      end
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      check("f_q4_last", 32'(q_count), 32'd4);
      check("f_stall_last", 32'(id_stall), 32'd1);
      check("f_slice3", 32'(bht_pc_slice), 32'd3);
      check("f_taken3", 32'(bht_branch_taken), 32'd1);
      tick();
      check("f_q3", 32'(q_count), 32'd3);
      check("f_lookup_after", 32'(id_predict_valid), 32'd1);
      check("f_nostall_after", 32'(id_stall), 32'd0);
      id_is_branch = 1'b0;
      for (int j = 4; j <= 6; j++) begin
         #1;
         check($sformatf("o_attempt%0d", j), 32'(bht_attempt_branch), 32'd1);
         check($sformatf("o_slice%0d", j), 32'(bht_pc_slice), 32'(j));
         check($sformatf("o_taken%0d", j), 32'(bht_branch_taken), 32'(j % 2));
         tick();
      end
      check("o_q0", 32'(q_count), 32'd0);

      // Asynchronous reset discards queued updates
      id_is_branch = 1'b1;
      for (int i = 0; i < 3; i++) begin
         ex(1'b1, 3'(i + 1), 1'b0, 1'b0);
         tick();
      end
      ex(1'b0, 3'd0, 1'b0, 1'b0);
      #1;
      check("r_q3", 32'(q_count), 32'd3);
      rst = 1'b1;
      #1;
      check("r_q0", 32'(q_count), 32'd0);
      check("r_attempt", 32'(bht_attempt_branch), 32'd0);
      check("r_resolve", 32'(resolve_count), 32'd0);
      check("r_mispred", 32'(mispredict_count), 32'd0);
      check("r_pvalid", 32'(id_predict_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      id_is_branch = 1'b0;
      tick();
      check("r_post_attempt", 32'(bht_attempt_branch), 32'd0);
      check("r_post_q", 32'(q_count), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
